interp_job_scheduler: RTL and testbench

Job sequencer that sits in front of the `interpolation` engine. The host pushes crop/scale jobs (H0, V0, SW, SH) into a small queue. The scheduler validates each job, launches the engine with a one-cycle START, and counts the 289 (17×17) output pixels. It then reports DONE, ERR or TIMEOUT per job, so the host never drives START directly or tracks engine progress.

---
 rtl/interp_pkg.sv | 38 +++
 rtl/interp_job_fifo.sv | 59 +++++
 rtl/interp_job_scheduler.sv | 162 ++++++++++++++++
 tb/tb_interp_job_scheduler.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/interp_pkg.sv
// Shared definitions for the interpolation job scheduler and the engine's
// bench model: job descriptor, image/grid geometry, scheduler states and
// engine handshake latencies.
package interp_pkg;

  localparam int unsigned GRID       = 17;
  localparam int unsigned OUT_PIXELS = GRID * GRID;
  localparam int unsigned IMG_DIM    = 64;

  // Cycles from the ENG_START cycle to the engine's first O_VALID beat.
  localparam int unsigned ENG_FIRST_VALID_LAT = 2;
  // Minimum cycles from a DONE pulse to the next ENG_START.
  localparam int unsigned ENG_DONE_TO_RESTART = 2;

  typedef struct packed {
    logic [5:0] h0;
    logic [5:0] v0;
    logic [3:0] sw;
    logic [3:0] sh;
  } job_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2
  } sched_state_t;

  // Window must be non-empty and lie entirely inside the image.
  function automatic logic job_is_valid(input job_t j);
    logic [6:0] h_end;
    logic [6:0] v_end;
    h_end = {1'b0, j.h0} + {3'b000, j.sw};
    v_end = {1'b0, j.v0} + {3'b000, j.sh};
    return (j.sw != '0) && (j.sh != '0) &&
           (h_end <= 7'(IMG_DIM)) && (v_end <= 7'(IMG_DIM));
  endfunction

endpackage

// File: rtl/interp_job_fifo.sv
// Synchronous FIFO of job descriptors, DEPTH entries (power of two).
// Ports:
//   clk, RST_N       clock, asynchronous active-low reset (empties queue)
//   push, push_data  write request; ignored when full
//   pop, pop_data    read request; pop_data shows the head entry
//   full, empty      occupancy flags from the registered count
//   count            number of stored entries
module interp_job_fifo
  import interp_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     RST_N,
  input  logic                     push,
  input  job_t                     push_data,
  input  logic                     pop,
  output job_t                     pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  job_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == FULL_COUNT);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/interp_job_scheduler.sv
// Job sequencer in front of the interpolation engine. Queues host jobs,
// validates each at pop, launches the engine with a one-cycle START, counts
// output beats and reports DONE / ERR / TIMEOUT per job.
// Ports:
//   clk, RST_N                  clock, asynchronous active-low reset
//   JOB_VALID/JOB_READY         host job handshake (push = VALID & READY)
//   JOB_H0/V0/SW/SH             job window origin and size
//   ENG_START, ENG_H0/V0/SW/SH  engine launch pulse and held parameters
//   ENG_O_VALID                 engine output beat
//   BUSY                        job launched and not finished
//   DONE, ERR, TIMEOUT          one-cycle completion/reject/abort pulses
//   PIX_CNT                     beats counted for the current job
module interp_job_scheduler #(
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned OUT_PIXELS    = interp_pkg::OUT_PIXELS,
  parameter int unsigned TIMEOUT_LIMIT = 400
) (
  input  logic       clk,
  input  logic       RST_N,
  input  logic       JOB_VALID,
  output logic       JOB_READY,
  input  logic [5:0] JOB_H0,
  input  logic [5:0] JOB_V0,
  input  logic [3:0] JOB_SW,
  input  logic [3:0] JOB_SH,
  output logic       ENG_START,
  output logic [5:0] ENG_H0,
  output logic [5:0] ENG_V0,
  output logic [3:0] ENG_SW,
  output logic [3:0] ENG_SH,
  input  logic       ENG_O_VALID,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR,
  output logic       TIMEOUT,
  output logic [8:0] PIX_CNT
);

  import interp_pkg::*;

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned WW = $clog2(TIMEOUT_LIMIT + 1);
  localparam logic [CW-1:0] FULL_COUNT     = DEPTH[CW-1:0];
  localparam logic [8:0]    LAST_BEAT      = 9'(OUT_PIXELS - 1);
  localparam logic [WW-1:0] LAST_RUN_CYCLE = WW'(TIMEOUT_LIMIT - 1);

  sched_state_t  state;
  sched_state_t  state_next;
  job_t          push_job;
  job_t          head_job;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          pop;
  logic          load;
  logic          err_next;
  logic          done_next;
  logic          timeout_next;
  logic          done_q;
  logic          err_q;
  logic          timeout_q;
  logic [8:0]    pix_cnt;
  logic [WW-1:0] wd_cnt;

  assign push_job  = '{h0: JOB_H0, v0: JOB_V0, sw: JOB_SW, sh: JOB_SH};
  assign JOB_READY = !fifo_full;

  interp_job_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .RST_N    (RST_N),
    .push     (JOB_VALID),
    .push_data(push_job),
    .pop      (pop),
    .pop_data (head_job),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (RST_N) assert (fifo_full == (fifo_count == FULL_COUNT));
  end

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_next;
  end

  // The IDLE cycle carrying a DONE/TIMEOUT pulse does not pop, so the engine
  // always sees at least one idle cycle between jobs.
  always_comb begin
    state_next   = state;
    pop          = 1'b0;
    load         = 1'b0;
    err_next     = 1'b0;
    done_next    = 1'b0;
    timeout_next = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty && !done_q && !timeout_q) begin
          pop = 1'b1;
          if (job_is_valid(head_job)) begin
            load       = 1'b1;
            state_next = LAUNCH;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      LAUNCH: state_next = RUN;
      RUN: begin
        if (ENG_O_VALID && (pix_cnt == LAST_BEAT)) begin
          done_next  = 1'b1;
          state_next = IDLE;
        end else if (wd_cnt == LAST_RUN_CYCLE) begin
          timeout_next = 1'b1;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      ENG_H0    <= '0;
      ENG_V0    <= '0;
      ENG_SW    <= '0;
      ENG_SH    <= '0;
      pix_cnt   <= '0;
      wd_cnt    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      done_q    <= done_next;
      err_q     <= err_next;
      timeout_q <= timeout_next;
      if (load) begin
        ENG_H0  <= head_job.h0;
        ENG_V0  <= head_job.v0;
        ENG_SW  <= head_job.sw;
        ENG_SH  <= head_job.sh;
        pix_cnt <= '0;
      end else if ((state == RUN) && ENG_O_VALID) begin
        pix_cnt <= pix_cnt + 1'b1;
      end
      if (state == LAUNCH)   wd_cnt <= '0;
      else if (state == RUN) wd_cnt <= wd_cnt + 1'b1;
    end
  end

  assign ENG_START = (state == LAUNCH);
  assign BUSY      = (state != IDLE);
  assign DONE      = done_q;
  assign ERR       = err_q;
  assign TIMEOUT   = timeout_q;
  assign PIX_CNT   = pix_cnt;

endmodule

// File: tb/tb_interp_job_scheduler.sv
// Directed bench for interp_job_scheduler with a simple engine model that
// answers each ENG_START with OUT_PIXELS consecutive O_VALID beats.
module tb_interp_job_scheduler;
  import interp_pkg::*;

  localparam int unsigned TO_LIMIT = 400;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       job_valid;
  logic       job_ready;
  logic [5:0] job_h0, job_v0;
  logic [3:0] job_sw, job_sh;
  logic       eng_start;
  logic [5:0] eng_h0, eng_v0;
  logic [3:0] eng_sw, eng_sh;
  logic       model_valid;
  logic       stray_valid;
  logic       eng_live;
  logic       busy, done, err, timeout;
  logic [8:0] pix_cnt;

  int cyc = 0;
  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  interp_job_scheduler #(
    .DEPTH(4),
    .OUT_PIXELS(289),
    .TIMEOUT_LIMIT(TO_LIMIT)
  ) dut (
    .clk        (clk),
    .RST_N      (rst_n),
    .JOB_VALID  (job_valid),
    .JOB_READY  (job_ready),
    .JOB_H0     (job_h0),
    .JOB_V0     (job_v0),
    .JOB_SW     (job_sw),
    .JOB_SH     (job_sh),
    .ENG_START  (eng_start),
    .ENG_H0     (eng_h0),
    .ENG_V0     (eng_v0),
    .ENG_SW     (eng_sw),
    .ENG_SH     (eng_sh),
    .ENG_O_VALID(model_valid | stray_valid),
    .BUSY       (busy),
    .DONE       (done),
    .ERR        (err),
    .TIMEOUT    (timeout),
    .PIX_CNT    (pix_cnt)
  );

  // Engine model: value set at the negedge of cycle k is the beat of cycle k.
  initial begin : engine_model
    int lead;
    int left;
    lead = 0;
    left = 0;
    model_valid = 1'b0;
    forever begin
      @(negedge clk);
      model_valid = 1'b0;
      if (rst_n !== 1'b1) begin
        left = 0;
      end else if (eng_start) begin
        lead = ENG_FIRST_VALID_LAT - 1;
        left = eng_live ? OUT_PIXELS : 0;
      end else if (left > 0) begin
        if (lead > 0) lead--;
        else begin
          model_valid = 1'b1;
          left--;
        end
      end
    end
  end

  task automatic offer(input job_t j);
    job_valid = 1'b1;
    job_h0 = j.h0;
    job_v0 = j.v0;
    job_sw = j.sw;
    job_sh = j.sh;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; job_valid = 1'b0; stray_valid = 1'b0; eng_live = 1'b1;
    job_h0 = '0; job_v0 = '0; job_sw = '0; job_sh = '0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (job_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_job_ready: got %b expected 1", job_ready); end
    tests_run++;
    if ({eng_start, busy, done, err, timeout} !== 5'b0) begin tests_failed++; $display("FAIL reset_flags: got %b expected 00000", {eng_start, busy, done, err, timeout}); end
    tests_run++;
    if ({eng_h0, eng_v0, eng_sw, eng_sh} !== 20'h0) begin tests_failed++; $display("FAIL reset_eng_params: got %h expected 00000", {eng_h0, eng_v0, eng_sw, eng_sh}); end
    tests_run++;
    if (pix_cnt !== 9'd0) begin tests_failed++; $display("FAIL reset_pix_cnt: got %0d expected 0", pix_cnt); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_job();
    int t_start, t_done, extra_starts;
    job_t j;
    j = '{h0: 6'd0, v0: 6'd0, sw: 4'd4, sh: 4'd4};
    offer(j);
    @(negedge clk); job_valid = 1'b0;
    tests_run++;
    if (eng_start !== 1'b0) begin tests_failed++; $display("FAIL single_no_early_start: got %b expected 0", eng_start); end
    @(negedge clk);
    tests_run++;
    if ({eng_start, busy} !== 2'b11) begin tests_failed++; $display("FAIL single_start_busy: got %b expected 11", {eng_start, busy}); end
    tests_run++;
    if ({eng_h0, eng_v0, eng_sw, eng_sh} !== j) begin tests_failed++; $display("FAIL single_eng_params: got %h expected %h", {eng_h0, eng_v0, eng_sw, eng_sh}, j); end
    tests_run++;
    if (pix_cnt !== 9'd0) begin tests_failed++; $display("FAIL single_launch_pix: got %0d expected 0", pix_cnt); end
    t_start = cyc; t_done = -1; extra_starts = 0;
    for (int i = 0; i < 600 && t_done < 0; i++) begin
      @(negedge clk);
      if (eng_start) extra_starts++;
      if (done) t_done = cyc;
    end
    tests_run++;
    if (t_done - t_start !== ENG_FIRST_VALID_LAT + OUT_PIXELS) begin tests_failed++; $display("FAIL single_done_latency: got %0d expected %0d", t_done - t_start, ENG_FIRST_VALID_LAT + OUT_PIXELS); end
    tests_run++;
    if (pix_cnt !== 9'd289) begin tests_failed++; $display("FAIL single_pix_final: got %0d expected 289", pix_cnt); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL single_busy_at_done: got %b expected 0", busy); end
    @(negedge clk);
    tests_run++;
    if (done !== 1'b0) begin tests_failed++; $display("FAIL single_done_one_cycle: got %b expected 0", done); end
    tests_run++;
    if (extra_starts !== 0) begin tests_failed++; $display("FAIL single_extra_start: got %0d expected 0", extra_starts); end
  endtask

  task automatic test_invalid_jobs();
    job_t inv [3];
    logic [11:0] err_seen;
    int starts, other_pulses;
    inv[0] = '{h0: 6'd0,  v0: 6'd0,  sw: 4'd0, sh: 4'd4};
    inv[1] = '{h0: 6'd62, v0: 6'd0,  sw: 4'd4, sh: 4'd4};
    inv[2] = '{h0: 6'd0,  v0: 6'd60, sw: 4'd4, sh: 4'd5};
    err_seen = '0; starts = 0; other_pulses = 0;
    for (int k = 0; k < 12; k++) begin
      if (k < 3) offer(inv[k]);
      else job_valid = 1'b0;
      err_seen[k] = err;
      if (eng_start) starts++;
      if (done || timeout) other_pulses++;
      @(negedge clk);
    end
    tests_run++;
    if (err_seen !== 12'h01C) begin tests_failed++; $display("FAIL invalid_err_pulses: got %b expected %b", err_seen, 12'h01C); end
    tests_run++;
    if (starts !== 0) begin tests_failed++; $display("FAIL invalid_no_start: got %0d expected 0", starts); end
    tests_run++;
    if (other_pulses !== 0) begin tests_failed++; $display("FAIL invalid_other_pulses: got %0d expected 0", other_pulses); end
    tests_run++;
    if ({job_ready, busy} !== 2'b10) begin tests_failed++; $display("FAIL invalid_queue_idle: got %b expected 10", {job_ready, busy}); end
  endtask

  task automatic test_queue_full();
    job_t a;
    job_t q [5];
    logic [4:0] ready_seen;
    int t_launch, t_to, busy_drops, late_starts;
    eng_live = 1'b0;
    a = '{h0: 6'd60, v0: 6'd60, sw: 4'd4, sh: 4'd4};
    q[0] = '{h0: 6'd1, v0: 6'd2, sw: 4'd3, sh: 4'd4};
    q[1] = '{h0: 6'd5, v0: 6'd6, sw: 4'd7, sh: 4'd8};
    q[2] = '{h0: 6'd9, v0: 6'd9, sw: 4'd9, sh: 4'd9};
    q[3] = '{h0: 6'd2, v0: 6'd3, sw: 4'd1, sh: 4'd1};
    q[4] = '{h0: 6'd4, v0: 6'd4, sw: 4'd4, sh: 4'd4};
    offer(a);
    @(negedge clk); job_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (eng_start !== 1'b1) begin tests_failed++; $display("FAIL full_boundary_launch: got %b expected 1", eng_start); end
    tests_run++;
    if ({eng_h0, eng_v0, eng_sw, eng_sh} !== a) begin tests_failed++; $display("FAIL full_boundary_params: got %h expected %h", {eng_h0, eng_v0, eng_sw, eng_sh}, a); end
    t_launch = cyc;
    ready_seen = '0;
    for (int k = 0; k < 5; k++) begin
      offer(q[k]);
      ready_seen[k] = job_ready;
      @(negedge clk);
    end
    job_valid = 1'b0;
    tests_run++;
    if (ready_seen !== 5'b01111) begin tests_failed++; $display("FAIL full_ready_pattern: got %b expected 01111", ready_seen); end
    @(negedge clk);
    tests_run++;
    if (job_ready !== 1'b0) begin tests_failed++; $display("FAIL full_ready_held_low: got %b expected 0", job_ready); end
    t_to = -1; busy_drops = 0;
    for (int i = 0; i < 600 && t_to < 0; i++) begin
      @(negedge clk);
      if (timeout) t_to = cyc;
      else if (!busy) busy_drops++;
    end
    tests_run++;
    if (t_to - t_launch !== TO_LIMIT + 1) begin tests_failed++; $display("FAIL full_timeout_latency: got %0d expected %0d", t_to - t_launch, TO_LIMIT + 1); end
    tests_run++;
    if (busy_drops !== 0) begin tests_failed++; $display("FAIL full_busy_in_run: got %0d drops expected 0", busy_drops); end
    tests_run++;
    if ({busy, pix_cnt} !== 10'd0) begin tests_failed++; $display("FAIL full_timeout_state: got busy=%b pix=%0d expected busy=0 pix=0", busy, pix_cnt); end
    @(negedge clk);
    tests_run++;
    if ({timeout, eng_start} !== 2'b00) begin tests_failed++; $display("FAIL full_gap_cycle: got %b expected 00", {timeout, eng_start}); end
    @(negedge clk);
    tests_run++;
    if (eng_start !== 1'b1) begin tests_failed++; $display("FAIL full_second_launch: got %b expected 1", eng_start); end
    tests_run++;
    if ({eng_h0, eng_v0, eng_sw, eng_sh} !== q[0]) begin tests_failed++; $display("FAIL full_second_params: got %h expected %h", {eng_h0, eng_v0, eng_sw, eng_sh}, q[0]); end
    tests_run++;
    if (job_ready !== 1'b1) begin tests_failed++; $display("FAIL full_ready_after_pop: got %b expected 1", job_ready); end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    late_starts = 0;
    repeat (6) begin
      @(negedge clk);
      if (eng_start || busy) late_starts++;
    end
    tests_run++;
    if (late_starts !== 0) begin tests_failed++; $display("FAIL full_reset_drops_queue: got %0d starts expected 0", late_starts); end
    eng_live = 1'b1;
  endtask

  task automatic test_back_to_back();
    job_t tj [2];
    int t0, starts, dones, stable_bad, zero_bad, cur;
    int t_s [2];
    int t_d [2];
    tj[0] = '{h0: 6'd1,  v0: 6'd1,  sw: 4'd2,  sh: 4'd2};
    tj[1] = '{h0: 6'd10, v0: 6'd20, sw: 4'd15, sh: 4'd15};
    t_s[0] = -1000; t_s[1] = -1000; t_d[0] = -1000; t_d[1] = -1000;
    starts = 0; dones = 0; stable_bad = 0; zero_bad = 0; cur = 0;
    offer(tj[0]); t0 = cyc;
    @(negedge clk); offer(tj[1]);
    @(negedge clk); job_valid = 1'b0;
    for (int i = 0; i < 900 && dones < 2; i++) begin
      if (eng_start) begin
        if (starts < 2) begin t_s[starts] = cyc; cur = starts; end
        starts++;
        if (pix_cnt !== 9'd0) zero_bad++;
      end
      if (busy && ({eng_h0, eng_v0, eng_sw, eng_sh} !== tj[cur])) stable_bad++;
      if (done) begin
        if (dones < 2) t_d[dones] = cyc;
        dones++;
      end
      @(negedge clk);
    end
    tests_run++;
    if ({starts, dones} !== {32'd2, 32'd2}) begin tests_failed++; $display("FAIL b2b_counts: got starts=%0d dones=%0d expected 2/2", starts, dones); end
    tests_run++;
    if (t_s[0] - t0 !== 2) begin tests_failed++; $display("FAIL b2b_first_start: got %0d expected 2", t_s[0] - t0); end
    tests_run++;
    if (stable_bad !== 0) begin tests_failed++; $display("FAIL b2b_eng_stable: got %0d bad cycles expected 0", stable_bad); end
    tests_run++;
    if (t_s[1] - t_d[0] !== ENG_DONE_TO_RESTART) begin tests_failed++; $display("FAIL b2b_restart_gap: got %0d expected %0d", t_s[1] - t_d[0], ENG_DONE_TO_RESTART); end
    tests_run++;
    if (t_d[1] - t_s[1] !== ENG_FIRST_VALID_LAT + OUT_PIXELS) begin tests_failed++; $display("FAIL b2b_second_done: got %0d expected %0d", t_d[1] - t_s[1], ENG_FIRST_VALID_LAT + OUT_PIXELS); end
    tests_run++;
    if (zero_bad !== 0) begin tests_failed++; $display("FAIL b2b_launch_pix_clear: got %0d expected 0", zero_bad); end
  endtask

  task automatic test_stray_and_reset();
    int reached, pulses;
    for (int k = 0; k < 3; k++) begin
      stray_valid = 1'b1;
      @(negedge clk);
      tests_run++;
      if (pix_cnt !== 9'd289) begin tests_failed++; $display("FAIL stray_pix_hold: got %0d expected 289", pix_cnt); end
    end
    stray_valid = 1'b0;
    offer('{h0: 6'd5, v0: 6'd5, sw: 4'd3, sh: 4'd3});
    @(negedge clk); offer('{h0: 6'd7, v0: 6'd7, sw: 4'd2, sh: 4'd2});
    @(negedge clk); job_valid = 1'b0;
    reached = 0;
    for (int i = 0; i < 400 && reached == 0; i++) begin
      if (pix_cnt == 9'd100) reached = 1;
      else @(negedge clk);
    end
    tests_run++;
    if (reached !== 1) begin tests_failed++; $display("FAIL reset_reach_pix100: got %0d expected 1", reached); end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({eng_start, busy, done, err, timeout, job_ready} !== 6'b000001) begin tests_failed++; $display("FAIL midrun_reset_flags: got %b expected 000001", {eng_start, busy, done, err, timeout, job_ready}); end
    tests_run++;
    if ({eng_h0, eng_v0, eng_sw, eng_sh, pix_cnt} !== 29'h0) begin tests_failed++; $display("FAIL midrun_reset_data: got %h expected 0", {eng_h0, eng_v0, eng_sw, eng_sh, pix_cnt}); end
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 2) rst_n = 1'b1;
      if (done || err || timeout || eng_start || busy) pulses++;
    end
    tests_run++;
    if (pulses !== 0) begin tests_failed++; $display("FAIL midrun_reset_quiet: got %0d events expected 0", pulses); end
    tests_run++;
    if (job_ready !== 1'b1) begin tests_failed++; $display("FAIL midrun_reset_queue_empty: got %b expected 1", job_ready); end
  endtask

  initial begin
    test_reset();
    test_single_job();
    test_invalid_jobs();
    test_queue_full();
    test_back_to_back();
    test_stray_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
